enc_controller: RTL

//  Sequences the encoder datapath (message buffer + parity LFSR) per codeword.

---
 rtl/enc_controller_if.sv | 29 ++
 rtl/enc_controller.sv | 81 ++++++++
 2 files changed

// File: rtl/enc_controller_if.sv
// enc_controller_if: handshake, stall and output-framing signals around the encoder controller.
interface enc_controller_if #(
    parameter int CW_CNT_W = 16
);
    logic                clr;
    logic                gen_valid;
    logic                gen_ready;
    logic                out_ready;
    logic                con_stall;
    logic                con_par_shift;
    logic                out_valid;
    logic                out_par_sel;
    logic                out_sop;
    logic                out_eop;
    logic [CW_CNT_W-1:0] cw_cnt;
    logic                busy;

    modport master (
        input  clr, gen_valid, out_ready,
        output gen_ready, con_stall, con_par_shift, out_valid, out_par_sel,
               out_sop, out_eop, cw_cnt, busy
    );

    modport slave (
        output clr, gen_valid, out_ready,
        input  gen_ready, con_stall, con_par_shift, out_valid, out_par_sel,
               out_sop, out_eop, cw_cnt, busy
    );
endinterface

// File: rtl/enc_controller.sv
// enc_controller: accepts message beats, then issues parity beats, framing each codeword
// with sop/eop through a single-entry output register.
module enc_controller #(
    parameter int ENC_SYM     = 4,
    parameter int ENC_MES_LEN = 64,
    parameter int ENC_PAR_LEN = 16,
    parameter int CW_CNT_W    = 16
) (
    input logic              clk,
    input logic              rst_n,
    enc_controller_if.master bus
);
    localparam int MES_BEATS = ENC_MES_LEN / ENC_SYM;
    localparam int PAR_BEATS = ENC_PAR_LEN / ENC_SYM;
    localparam int MAX_BEATS = MES_BEATS > PAR_BEATS ? MES_BEATS : PAR_BEATS;
    localparam int BW        = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {MES, PAR} state_e;

    state_e              state_q, state_d;
    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [CW_CNT_W-1:0] cw_cnt_q, cw_cnt_d;
    logic                out_valid_q, out_par_sel_q, out_sop_q, out_eop_q;
    logic                free, acc, iss, fire, last_beat;

    // free: output slot is empty or its beat drains this cycle
    always_comb begin
        free       = !out_valid_q || bus.out_ready;
        acc        = state_q == MES && bus.gen_valid && free && !bus.clr;
        iss        = state_q == PAR && free && !bus.clr;
        fire       = acc || iss;
        last_beat  = beat_cnt_q == (state_q == MES ? BW'(MES_BEATS - 1) : BW'(PAR_BEATS - 1));
        beat_cnt_d = !fire ? beat_cnt_q : last_beat ? '0 : beat_cnt_q + BW'(1);
        state_d    = fire && last_beat ? (state_q == MES ? PAR : MES) : state_q;
        cw_cnt_d   = iss && last_beat ? cw_cnt_q + CW_CNT_W'(1) : cw_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= MES;
            beat_cnt_q    <= '0;
            cw_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_par_sel_q <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
        end else if (bus.clr) begin
            state_q       <= MES;
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_par_sel_q <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            cw_cnt_q   <= cw_cnt_d;
            if (fire) begin
                out_valid_q   <= 1'b1;
                out_par_sel_q <= state_q == PAR;
                out_sop_q     <= state_q == MES && beat_cnt_q == '0;
                out_eop_q     <= iss && last_beat;
            end else if (bus.out_ready) begin
                out_valid_q   <= 1'b0;
                out_par_sel_q <= 1'b0;
                out_sop_q     <= 1'b0;
                out_eop_q     <= 1'b0;
            end
        end
    end

    assign bus.gen_ready     = state_q == MES && free && !bus.clr;
    assign bus.con_stall     = !acc;
    assign bus.con_par_shift = iss;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_par_sel   = out_par_sel_q;
    assign bus.out_sop       = out_sop_q;
    assign bus.out_eop       = out_eop_q;
    assign bus.cw_cnt        = cw_cnt_q;
    assign bus.busy          = state_q == PAR || beat_cnt_q != '0;
endmodule
